// File: rtl/gbar_resolver.sv
// Global-barrier responder: counts per-barrier core arrivals and pulses a release with the barrier ID.
// Optional GBAR_RESOLVER_PERF_EN adds release and busy-cycle performance counters.
module gbar_resolver #(
   parameter int unsigned NUM_BARRIERS = 8,
   parameter int unsigned NUM_CORES = 4,
   localparam int unsigned NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
   localparam int unsigned NC_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   input  logic [NB_WIDTH-1:0] req_id,
   input  logic [NC_WIDTH-1:0] req_size_m1,
   input  logic [NC_WIDTH-1:0] req_core_id,
   output logic                req_ready,
   output logic                rsp_valid,
   output logic [NB_WIDTH-1:0] rsp_id,
   input  logic                err_clear,
   output logic                err_dup,
   output logic                err_size,
   output logic                err_range,
`ifdef GBAR_RESOLVER_PERF_EN
   output logic [31:0]         perf_releases,
   output logic [31:0]         perf_wait_cycles,
`endif
   output logic                busy
);

   localparam int unsigned CW = NC_WIDTH + 1;

   logic [NUM_CORES-1:0] mask_q  [NUM_BARRIERS];
   logic [CW-1:0]        count_q [NUM_BARRIERS];
   logic [NC_WIDTH-1:0]  size_q  [NUM_BARRIERS];

   logic                ready_q;
   logic                rsp_valid_q;
   logic [NB_WIDTH-1:0] rsp_id_q;
   logic                err_dup_q, err_size_q, err_range_q;

   logic [NUM_CORES-1:0] cur_mask;
   logic [CW-1:0]        cur_count;
   logic [NC_WIDTH-1:0]  cur_size;
   logic [NC_WIDTH-1:0]  eff_size;
   logic accept, range_bad, size_bad, dup, idle, mismatch, do_count, complete;

   // Decode the incoming arrival against the addressed barrier's state
   always_comb begin
      cur_mask  = mask_q[req_id];
      cur_count = count_q[req_id];
      cur_size  = size_q[req_id];
      accept    = req_valid && ready_q;
      range_bad = 32'(req_core_id) >= NUM_CORES;
      size_bad  = 32'(req_size_m1) >= NUM_CORES;
      dup       = range_bad ? 1'b0 : cur_mask[req_core_id];
      idle      = (cur_count == '0);
      eff_size  = idle ? req_size_m1 : cur_size;
      mismatch  = !idle && (req_size_m1 != cur_size);
      do_count  = accept && !range_bad && !size_bad && !dup;
      complete  = do_count && ((cur_count + CW'(1)) == (CW'(eff_size) + CW'(1)));
   end

   always_comb begin
      busy = 1'b0;
      for (int b = 0; b < int'(NUM_BARRIERS); b++) begin
         if (count_q[b] != '0) busy = 1'b1;
      end
   end

   // Barrier state: completion clears the episode in the same edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < int'(NUM_BARRIERS); b++) begin
            mask_q[b]  <= '0;
            count_q[b] <= '0;
            size_q[b]  <= '0;
         end
      end else if (do_count) begin
         if (complete) begin
            mask_q[req_id]  <= '0;
            count_q[req_id] <= '0;
         end else begin
            mask_q[req_id][req_core_id] <= 1'b1;
            count_q[req_id]             <= cur_count + CW'(1);
            if (idle) size_q[req_id] <= req_size_m1;
         end
      end
   end

   // Handshake, release pulse and sticky error flags (new error beats clear)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         err_dup_q   <= 1'b0;
         err_size_q  <= 1'b0;
         err_range_q <= 1'b0;
      end else begin
         ready_q     <= 1'b1;
         rsp_valid_q <= complete;
         if (complete) rsp_id_q <= req_id;
         err_range_q <= (accept && range_bad) || (err_range_q && !err_clear);
         err_size_q  <= (accept && !range_bad && (size_bad || (!dup && mismatch)))
                        || (err_size_q && !err_clear);
         err_dup_q   <= (accept && !range_bad && !size_bad && dup) || (err_dup_q && !err_clear);
      end
   end

`ifdef GBAR_RESOLVER_PERF_EN
   logic [31:0] perf_rel_q, perf_wait_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_rel_q  <= '0;
         perf_wait_q <= '0;
      end else begin
         if (rsp_valid_q) perf_rel_q <= perf_rel_q + 32'd1;
         if (busy) perf_wait_q <= perf_wait_q + 32'd1;
      end
   end

   assign perf_releases    = perf_rel_q;
   assign perf_wait_cycles = perf_wait_q;
`endif

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign err_dup   = err_dup_q;
   assign err_size  = err_size_q;
   assign err_range = err_range_q;

endmodule

// File: tb/tb_gbar_resolver.sv
// Scoreboard bench for gbar_resolver: expected releases are queued at issue and checked by a monitor.
module tb_gbar_resolver;

   typedef struct {
      int id;
      int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic [2:0] req_id = '0;
   logic [1:0] req_size_m1 = '0;
   logic [1:0] req_core_id = '0;
   logic       err_clear = 1'b0;
   logic       req_ready, rsp_valid, err_dup, err_size, err_range, busy;
   logic [2:0] rsp_id;

   logic       r3_valid = 1'b0;
   logic [2:0] r3_id = '0;
   logic [1:0] r3_size_m1 = '0;
   logic [1:0] r3_core_id = '0;
   logic       r3_ready, r3_rsp_valid, r3_err_dup, r3_err_size, r3_err_range, r3_busy;
   logic [2:0] r3_rsp_id;

`ifdef GBAR_RESOLVER_PERF_EN
   logic [31:0] perf_rel, perf_wait, perf_rel3, perf_wait3;
`endif

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   exp_t exp_q[$];

   gbar_resolver #(.NUM_BARRIERS(8), .NUM_CORES(4)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_id(req_id),
      .req_size_m1(req_size_m1), .req_core_id(req_core_id), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .err_clear(err_clear), .err_dup(err_dup),
      .err_size(err_size), .err_range(err_range),
`ifdef GBAR_RESOLVER_PERF_EN
      .perf_releases(perf_rel), .perf_wait_cycles(perf_wait),
`endif
      .busy(busy)
   );

   gbar_resolver #(.NUM_BARRIERS(8), .NUM_CORES(3)) dut3 (
      .clk(clk), .reset(reset), .req_valid(r3_valid), .req_id(r3_id),
      .req_size_m1(r3_size_m1), .req_core_id(r3_core_id), .req_ready(r3_ready),
      .rsp_valid(r3_rsp_valid), .rsp_id(r3_rsp_id), .err_clear(1'b0), .err_dup(r3_err_dup),
      .err_size(r3_err_size), .err_range(r3_err_range),
`ifdef GBAR_RESOLVER_PERF_EN
      .perf_releases(perf_rel3), .perf_wait_cycles(perf_wait3),
`endif
      .busy(r3_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One accepted request on the main DUT; queues a release expected during the following cycle
   task automatic req(input int id, input int sz, input int core, input bit rel);
      exp_t e;
      req_id      = 3'(id);
      req_size_m1 = 2'(sz);
      req_core_id = 2'(core);
      req_valid   = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (rel) begin
         e.id  = id;
         e.cyc = cyc;
         exp_q.push_back(e);
      end
   endtask

   task automatic req3(input int id, input int sz, input int core);
      r3_id      = 3'(id);
      r3_size_m1 = 2'(sz);
      r3_core_id = 2'(core);
      r3_valid   = 1'b1;
      @(posedge clk);
      #1;
      r3_valid = 1'b0;
   endtask

   task automatic clear_errs();
      err_clear = 1'b1;
      @(posedge clk);
      #1;
      err_clear = 1'b0;
   endtask

   // Monitor: every release pulse must match the head of the scoreboard in ID and cycle
   always @(negedge clk) begin
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_release_id", int'(rsp_id), -1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("release_id", int'(rsp_id), e.id);
            chk("release_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("reset_ready", int'(req_ready), 0);
      chk("reset_rsp_valid", int'(rsp_valid), 0);
      chk("reset_rsp_id", int'(rsp_id), 0);
      chk("reset_errs", int'({err_dup, err_size, err_range}), 0);
      chk("reset_busy", int'(busy), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_reset", int'(req_ready), 1);

      // Full arrival of four cores
      req(3, 3, 0, 0);
      chk("busy_first_arrival", int'(busy), 1);
      req(3, 3, 1, 0);
      req(3, 3, 2, 0);
      chk("busy_mid_arrival", int'(busy), 1);
      req(3, 3, 3, 1);
      chk("busy_after_release", int'(busy), 0);

      // Duplicate arrival
      req(1, 1, 2, 0);
      chk("no_dup_yet", int'(err_dup), 0);
      req(1, 1, 2, 0);
      chk("err_dup_set", int'(err_dup), 1);
      req(1, 1, 0, 1);
      clear_errs();
      chk("err_dup_cleared", int'(err_dup), 0);

      // Size mismatch counts against latched size
      req(0, 1, 0, 0);
      chk("no_size_err_yet", int'(err_size), 0);
      req(0, 2, 1, 1);
      chk("err_size_mismatch", int'(err_size), 1);
      clear_errs();
      chk("err_size_cleared", int'(err_size), 0);

      // Clear and new error in the same cycle: error wins
      req(0, 1, 0, 0);
      err_clear = 1'b1;
      req(0, 0, 1, 1);
      err_clear = 1'b0;
      chk("err_beats_clear", int'(err_size), 1);
      clear_errs();

      // Back-to-back single-core barriers
      req(5, 0, 0, 1);
      req(6, 0, 1, 1);

      // Same ID restarts immediately with a freshly latched size
      req(7, 0, 0, 1);
      req(7, 1, 0, 0);
      req(7, 0, 1, 1);
      clear_errs();

      // Independent barriers
      req(2, 1, 0, 0);
      req(3, 0, 0, 1);
      chk("busy_other_open", int'(busy), 1);
      req(2, 1, 1, 1);
      chk("errs_independent", int'({err_dup, err_size, err_range}), 0);

      // Reset mid-barrier discards arrivals
      req(2, 3, 0, 0);
      req(2, 3, 1, 0);
      chk("busy_before_reset", int'(busy), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("ready_in_reset", int'(req_ready), 0);
      chk("busy_in_reset", int'(busy), 0);
      @(posedge clk);
      #1;
      chk("ready_held_in_reset", int'(req_ready), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_reset2", int'(req_ready), 1);
      req(2, 3, 0, 0);
      req(2, 3, 1, 0);
      req(2, 3, 2, 0);
      req(2, 3, 3, 1);

      // Range and size checks on the three-core instance
      req3(1, 1, 0);
      chk("r3_busy_open", int'(r3_busy), 1);
      req3(1, 1, 3);
      chk("r3_err_range", int'(r3_err_range), 1);
      chk("r3_busy_unchanged", int'(r3_busy), 1);
      chk("r3_no_release_on_range", int'(r3_rsp_valid), 0);
      req3(1, 1, 1);
      chk("r3_release_valid", int'(r3_rsp_valid), 1);
      chk("r3_release_id", int'(r3_rsp_id), 1);
      chk("r3_idle", int'(r3_busy), 0);
      req3(0, 3, 0);
      chk("r3_err_size_oor", int'(r3_err_size), 1);
      chk("r3_dropped_oor", int'(r3_busy), 0);
      chk("r3_no_dup", int'(r3_err_dup), 0);
      chk("main_no_range", int'(err_range), 0);

      repeat (3) @(posedge clk);
      #1;
      chk("pending_releases", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
